snes_pad_poller: RTL

- Parametrised successor to the single-pad NES/SNES interface.
- Polls NUM_PADS serial game controllers in parallel over a shared clock/latch pair and deserialises NUM_BITS per pad into active-high button vectors.
- Generates single-cycle press and release event pulses per button.
- Sits between the controller connector pins and the pinball game-logic and laser-projector control blocks, all on the 50 MHz domain.

---
 rtl/snes_pad_pkg.sv | 33 +++
 rtl/pad_edge_detect.sv | 45 ++++
 rtl/snes_pad_poller.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/snes_pad_pkg.sv
// Shared definitions for the SNES/NES pad poller.
//   - poll_state_t : poller FSM state encoding
//   - SNES_*       : bit positions within one pad's button vector
//                    (bit 0 is the first bit shifted out of the pad)
//   - DEFAULT_*    : pad timing defaults for a 50 MHz clk_50
package snes_pad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SAMPLE,
        ST_CLK_LO,
        ST_DONE
    } poll_state_t;

    localparam int unsigned SNES_B      = 0;
    localparam int unsigned SNES_Y      = 1;
    localparam int unsigned SNES_SELECT = 2;
    localparam int unsigned SNES_START  = 3;
    localparam int unsigned SNES_N      = 4;
    localparam int unsigned SNES_S      = 5;
    localparam int unsigned SNES_W      = 6;
    localparam int unsigned SNES_E      = 7;
    localparam int unsigned SNES_A      = 8;
    localparam int unsigned SNES_X      = 9;
    localparam int unsigned SNES_L      = 10;
    localparam int unsigned SNES_R      = 11;

    // 6 us half-period of pad_clk, 60 Hz poll rate
    localparam int unsigned DEFAULT_CLK_DIV     = 300;
    localparam int unsigned DEFAULT_POLL_PERIOD = 833333;

endpackage

// File: rtl/pad_edge_detect.sv
// Registered button-state comparator.
// On a load strobe the new vector becomes the current button state and the
// change against the previous state is reported as one-cycle pulses.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        one-cycle strobe: accept new_vec
//   new_vec     freshly sampled button vector, active-high
//   buttons     current button state
//   pressed     one-cycle pulse per bit on a 0->1 change
//   released    one-cycle pulse per bit on a 1->0 change
//   updated     one-cycle pulse when buttons actually changed
module pad_edge_detect
    import snes_pad_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] new_vec,
    output logic [WIDTH-1:0] buttons,
    output logic [WIDTH-1:0] pressed,
    output logic [WIDTH-1:0] released,
    output logic             updated
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buttons  <= '0;
            pressed  <= '0;
            released <= '0;
            updated  <= 1'b0;
        end else if (load) begin
            buttons  <= new_vec;
            pressed  <= new_vec & ~buttons;
            released <= ~new_vec & buttons;
            updated  <= (new_vec != buttons);
        end else begin
            pressed  <= '0;
            released <= '0;
            updated  <= 1'b0;
        end
    end

endmodule

// File: rtl/snes_pad_poller.sv
// Polls NUM_PADS serial NES/SNES controllers in parallel over a shared
// pad_clk/pad_latch pair and deserialises NUM_BITS per pad into active-high
// button vectors with per-button press/release pulses.
// Optional feature macro: PAD_PRESENCE_DETECT_EN
//   adds one extra clocked bit per poll (low = pad connected) and the
//   pad_present output; absent pads read as all-released.
// Ports:
//   clk_50       50 MHz system clock
//   reset_n      asynchronous active-low reset
//   pad_dout     serial data from each pad, active-low
//   poll_req     one-cycle request for an immediate poll
//   pad_clk      shared controller clock, idles high
//   pad_latch    shared controller latch, idles low
//   busy         high while a poll is in progress
//   updated      one-cycle pulse when buttons change to a new sample
//   buttons      pad p bit b at index p*NUM_BITS+b, active-high
//   pressed      one-cycle pulse per button on 0->1
//   released     one-cycle pulse per button on 1->0
//   pad_present  (PAD_PRESENCE_DETECT_EN only) per-pad connection flag
module snes_pad_poller
    import snes_pad_pkg::*;
#(
    parameter int unsigned NUM_PADS    = 2,
    parameter int unsigned NUM_BITS    = 16,
    parameter int unsigned CLK_DIV     = DEFAULT_CLK_DIV,
    parameter int unsigned POLL_PERIOD = DEFAULT_POLL_PERIOD
) (
    input  logic                         clk_50,
    input  logic                         reset_n,
    input  logic [NUM_PADS-1:0]          pad_dout,
    input  logic                         poll_req,
    output logic                         pad_clk,
    output logic                         pad_latch,
    output logic                         busy,
    output logic                         updated,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic [NUM_PADS*NUM_BITS-1:0] pressed,
    output logic [NUM_PADS*NUM_BITS-1:0] released
`ifdef PAD_PRESENCE_DETECT_EN
    ,
    output logic [NUM_PADS-1:0]          pad_present
`endif
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned TMR_W = $clog2(POLL_PERIOD);
    localparam int unsigned IDX_W = $clog2(NUM_BITS + 1);
    localparam int unsigned TOTAL = NUM_PADS * NUM_BITS;

`ifdef PAD_PRESENCE_DETECT_EN
    localparam int unsigned LAST_BIT = NUM_BITS;
`else
    localparam int unsigned LAST_BIT = NUM_BITS - 1;
`endif

    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(POLL_PERIOD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(LAST_BIT);

    // Reset: asynchronous assertion, deassertion aligned to clk_50
    logic [1:0] rst_pipe;
    logic       rst_n;

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            rst_pipe <= '0;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_n = rst_pipe[1];

    // Pad data synchroniser; lines idle high (released)
    logic [NUM_PADS-1:0] din_meta;
    logic [NUM_PADS-1:0] din_sync;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            din_meta <= '1;
            din_sync <= '1;
        end else begin
            din_meta <= pad_dout;
            din_sync <= din_meta;
        end
    end

    // Poll scheduling
    poll_state_t       state;
    logic [TMR_W-1:0]  timer;
    logic              pending;
    logic              take_poll;

    assign take_poll = (state == ST_IDLE) && pending;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            timer   <= '0;
            pending <= 1'b0;
        end else begin
            if (timer == TMR_LAST) begin
                timer <= '0;
            end else begin
                timer <= timer + TMR_W'(1);
            end

            // Any number of triggers before the FSM takes the request
            // collapse into a single pending poll.
            if (take_poll) begin
                pending <= 1'b0;
            end else if ((timer == TMR_LAST) || poll_req) begin
                pending <= 1'b1;
            end
        end
    end

    // Poll FSM
    logic [DIV_W-1:0]                   div_cnt;
    logic                               tick;
    logic                               latch_half;
    logic [IDX_W-1:0]                   bit_idx;
    logic [NUM_PADS-1:0][NUM_BITS-1:0]  shift_q;
    logic                               load_q;
`ifdef PAD_PRESENCE_DETECT_EN
    logic [NUM_PADS-1:0]                present_shift;
`endif

    assign tick = (div_cnt == '0);

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            div_cnt    <= '0;
            latch_half <= 1'b0;
            bit_idx    <= '0;
            shift_q    <= '0;
            load_q     <= 1'b0;
            pad_clk    <= 1'b1;
            pad_latch  <= 1'b0;
            busy       <= 1'b0;
`ifdef PAD_PRESENCE_DETECT_EN
            present_shift <= '0;
`endif
        end else begin
            load_q <= 1'b0;
            if (!tick) begin
                div_cnt <= div_cnt - DIV_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        state      <= ST_LATCH;
                        div_cnt    <= DIV_RELOAD;
                        latch_half <= 1'b0;
                        shift_q    <= '0;
                        pad_latch  <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                // Latch is held for two half-periods
                ST_LATCH: begin
                    if (tick) begin
                        div_cnt <= DIV_RELOAD;
                        if (!latch_half) begin
                            latch_half <= 1'b1;
                        end else begin
                            state     <= ST_SAMPLE;
                            pad_latch <= 1'b0;
                            bit_idx   <= '0;
                        end
                    end
                end

                // Bits enter at the MSB and move down, so after NUM_BITS
                // samples the first bit shifted sits in bit 0, the same
                // result as writing shift bit [bit_idx] directly.
                ST_SAMPLE: begin
                    if (tick) begin
                        for (int unsigned p = 0; p < NUM_PADS; p++) begin
`ifdef PAD_PRESENCE_DETECT_EN
                            if (bit_idx == LAST_IDX) begin
                                present_shift[p] <= ~din_sync[p];
                            end else begin
                                shift_q[p] <= {~din_sync[p], shift_q[p][NUM_BITS-1:1]};
                            end
`else
                            shift_q[p] <= {~din_sync[p], shift_q[p][NUM_BITS-1:1]};
`endif
                        end
                        state   <= ST_CLK_LO;
                        pad_clk <= 1'b0;
                        div_cnt <= DIV_RELOAD;
                    end
                end

                ST_CLK_LO: begin
                    if (tick) begin
                        pad_clk <= 1'b1;
                        div_cnt <= DIV_RELOAD;
                        if (bit_idx == LAST_IDX) begin
                            state  <= ST_DONE;
                            load_q <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            state   <= ST_SAMPLE;
                        end
                    end
                end

                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PAD_PRESENCE_DETECT_EN
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            pad_present <= '0;
        end else if (load_q) begin
            pad_present <= present_shift;
        end
    end
`endif

    // Absent pads read as all-released; releases on disconnect still fire
    // because the previous state is compared against zeros.
    logic [TOTAL-1:0] new_vec;

    always_comb begin
        new_vec = '0;
        for (int unsigned p = 0; p < NUM_PADS; p++) begin
`ifdef PAD_PRESENCE_DETECT_EN
            new_vec[p*NUM_BITS +: NUM_BITS] = shift_q[p] & {NUM_BITS{present_shift[p]}};
`else
            new_vec[p*NUM_BITS +: NUM_BITS] = shift_q[p];
`endif
        end
    end

    pad_edge_detect #(
        .WIDTH(TOTAL)
    ) u_edge (
        .clk      (clk_50),
        .rst_n    (rst_n),
        .load     (load_q),
        .new_vec  (new_vec),
        .buttons  (buttons),
        .pressed  (pressed),
        .released (released),
        .updated  (updated)
    );

endmodule
